// File: rtl/tug_playfield_if.sv
// Player press inputs and game-state outputs of the tug-of-war playfield.
// The driver of the presses uses master; the playfield itself uses slave.
interface tug_playfield_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  press_l;
  logic                  press_r;
  logic [NUM_LIGHTS-1:0] led;
  logic                  win_l;
  logic                  win_r;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;

  modport master (
    output press_l, press_r,
    input  led, win_l, win_r, score_l, score_r
  );

  modport slave (
    input  press_l, press_r,
    output led, win_l, win_r, score_l, score_r
  );
endinterface

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: edge-detects both presses, moves the light,
// detects round wins, holds the win display, keeps scores and ends the game.
//
// state | meaning
// PLAY  | light moves on single-player press edges
// WIN_L | left win displayed for HOLD_CYCLES cycles
// WIN_R | right win displayed for HOLD_CYCLES cycles
// DONE  | a player reached the max score; frozen until reset
module tug_playfield #(
  parameter int NUM_LIGHTS  = 9,
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W     = 3
) (
  input  logic            Clock,
  input  logic            reset,
  tug_playfield_if.slave  bus
);
  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [POS_W-1:0]   POS_C     = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [NUM_LIGHTS-1:0] LED_C  = NUM_LIGHTS'(1) << POS_C;

  typedef enum logic [1:0] {PLAY, WIN_L, WIN_R, DONE} state_t;

  state_t                state, state_nx;
  logic [POS_W-1:0]      pos, pos_nx;
  logic [HOLD_W-1:0]     hold_cnt, hold_nx;
  logic [SCORE_W-1:0]    score_l, score_l_nx, score_l_inc;
  logic [SCORE_W-1:0]    score_r, score_r_nx, score_r_inc;
  logic                  prev_l, prev_r;
  logic                  pulse_l, pulse_r;
  logic [NUM_LIGHTS-1:0] led, led_nx;
  logic                  win_l, win_l_nx, win_r, win_r_nx;

  assign pulse_l     = bus.press_l & ~prev_l;
  assign pulse_r     = bus.press_r & ~prev_r;
  assign score_l_inc = score_l + 1'b1;
  assign score_r_inc = score_r + 1'b1;

  // prev_* reset high so an input held through reset never yields a pulse
  always_ff @(posedge Clock) begin
    if (reset) begin
      state    <= PLAY;
      pos      <= POS_C;
      hold_cnt <= '0;
      score_l  <= '0;
      score_r  <= '0;
      prev_l   <= 1'b1;
      prev_r   <= 1'b1;
      led      <= LED_C;
      win_l    <= 1'b0;
      win_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      pos      <= pos_nx;
      hold_cnt <= hold_nx;
      score_l  <= score_l_nx;
      score_r  <= score_r_nx;
      prev_l   <= bus.press_l;
      prev_r   <= bus.press_r;
      led      <= led_nx;
      win_l    <= win_l_nx;
      win_r    <= win_r_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pos_nx     = pos;
    hold_nx    = hold_cnt;
    score_l_nx = score_l;
    score_r_nx = score_r;
    case (state)
      PLAY: begin
        if (pulse_l && !pulse_r) begin
          if (pos < POS_MAX) begin
            pos_nx = pos + 1'b1;
          end else begin
            score_l_nx = score_l_inc;
            hold_nx    = '0;
            state_nx   = (score_l_inc == SCORE_MAX) ? DONE : WIN_L;
          end
        end else if (pulse_r && !pulse_l) begin
          if (pos > '0) begin
            pos_nx = pos - 1'b1;
          end else begin
            score_r_nx = score_r_inc;
            hold_nx    = '0;
            state_nx   = (score_r_inc == SCORE_MAX) ? DONE : WIN_R;
          end
        end
      end
      WIN_L, WIN_R: begin
        hold_nx = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nx = PLAY;
          pos_nx   = POS_C;
          hold_nx  = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from next-state values so they leave flops directly
  always_comb begin
    led_nx   = '0;
    win_l_nx = 1'b0;
    win_r_nx = 1'b0;
    case (state_nx)
      PLAY:    led_nx   = NUM_LIGHTS'(1) << pos_nx;
      WIN_L:   win_l_nx = 1'b1;
      WIN_R:   win_r_nx = 1'b1;
      DONE: begin
        win_l_nx = (score_l_nx == SCORE_MAX);
        win_r_nx = (score_r_nx == SCORE_MAX);
      end
      default: ;
    endcase
  end

  assign bus.led     = led;
  assign bus.win_l   = win_l;
  assign bus.win_r   = win_r;
  assign bus.score_l = score_l;
  assign bus.score_r = score_r;
endmodule

// File: tb/tb_tug_playfield.sv
// Self-checking bench for tug_playfield: per-cycle vector table plus
// directed sequences for hold-time pulses, game over and reset priority.
module tb_tug_playfield;
  localparam logic [8:0] LED_C = 9'b000010000;

  typedef struct {
    logic       rst;
    logic       pl;
    logic       pr;
    logic [8:0] led;
    logic       wl;
    logic       wr;
    logic [2:0] sl;
    logic [2:0] sr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  tug_playfield_if #(.NUM_LIGHTS(9), .SCORE_W(3)) bus ();

  tug_playfield #(.NUM_LIGHTS(9), .HOLD_CYCLES(8), .SCORE_W(3)) dut (
    .Clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [8:0] led, input logic wl,
                           input logic wr, input logic [2:0] sl, input logic [2:0] sr);
    check({name, ".led"},     bus.led,     led);
    check({name, ".win_l"},   bus.win_l,   wl);
    check({name, ".win_r"},   bus.win_r,   wr);
    check({name, ".score_l"}, bus.score_l, sl);
    check({name, ".score_r"}, bus.score_r, sr);
  endtask

  function automatic void add(input logic r, input logic pl, input logic pr, input logic [8:0] led,
                              input logic wl, input logic wr, input logic [2:0] sl, input logic [2:0] sr);
    vec_t v;
    v.rst = r; v.pl = pl; v.pr = pr; v.led = led;
    v.wl = wl; v.wr = wr; v.sl = sl; v.sr = sr;
    vecs.push_back(v);
  endfunction

  task automatic pulse_r();
    bus.press_r = 1'b0;
    tick();
    bus.press_r = 1'b1;
    tick();
  endtask

  task automatic pulse_l();
    bus.press_l = 1'b0;
    tick();
    bus.press_l = 1'b1;
    tick();
  endtask

  // From centre: four moves then the winning press, then wait out the hold
  task automatic right_round(input logic [2:0] exp_sr);
    for (int p = 0; p < 5; p++) pulse_r();
    check_all($sformatf("round%0d_win", exp_sr), 9'b0, 1'b0, 1'b1, 3'd1, exp_sr);
    if (exp_sr != 3'd7) begin
      bus.press_r = 1'b0;
      repeat (8) tick();
      check_all($sformatf("round%0d_after", exp_sr), LED_C, 1'b0, 1'b0, 3'd1, exp_sr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.press_l = 1'b0;
    bus.press_r = 1'b1;

    // reset with press_r held high, then a single right edge and a left edge
    add(1, 0, 1, LED_C, 0, 0, 0, 0);
    add(1, 0, 1, LED_C, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, LED_C, 0, 0, 0, 0);
    add(0, 0, 0, LED_C, 0, 0, 0, 0);
    add(0, 0, 1, 9'b000001000, 0, 0, 0, 0);
    add(0, 0, 0, 9'b000001000, 0, 0, 0, 0);
    add(0, 1, 0, LED_C, 0, 0, 0, 0);
    add(0, 0, 0, LED_C, 0, 0, 0, 0);
    // walk left to the edge, then the winning press and exactly 8 display cycles
    for (int p = 5; p <= 8; p++) begin
      add(0, 1, 0, 9'(1 << p), 0, 0, 0, 0);
      add(0, 0, 0, 9'(1 << p), 0, 0, 0, 0);
    end
    add(0, 1, 0, 9'b0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 9'b0, 1, 0, 1, 0);
    add(0, 0, 0, LED_C, 0, 0, 1, 0);
    // simultaneous rising edges cancel; left alone then moves
    add(0, 1, 1, LED_C, 0, 0, 1, 0);
    add(0, 0, 1, LED_C, 0, 0, 1, 0);
    add(0, 1, 1, 9'b000100000, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      bus.press_l = vecs[i].pl;
      bus.press_r = vecs[i].pr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].wl, vecs[i].wr,
                vecs[i].sl, vecs[i].sr);
    end

    // right win from pos 5, then both inputs toggled through the hold
    for (int p = 0; p < 5; p++) pulse_r();
    check_all("walk_r", 9'b000000001, 1'b0, 1'b0, 3'd1, 3'd0);
    pulse_r();
    check_all("hold_entry", 9'b0, 1'b0, 1'b1, 3'd1, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      bus.press_l = k[0];
      bus.press_r = ~k[0];
      tick();
      if (k < 8) check_all($sformatf("hold%0d", k), 9'b0, 1'b0, 1'b1, 3'd1, 3'd1);
      else       check_all("hold_exit", LED_C, 1'b0, 1'b0, 3'd1, 3'd1);
    end
    bus.press_l = 1'b0;
    bus.press_r = 1'b0;

    // right wins until game over, then pulses are ignored
    for (int s = 2; s <= 7; s++) right_round(3'(s));
    for (int i = 0; i < 20; i++) begin
      bus.press_l = 1'b0;
      bus.press_r = 1'b0;
      tick();
      bus.press_l = 1'b1;
      tick();
      bus.press_l = 1'b0;
      bus.press_r = 1'b1;
      tick();
      if (i % 5 == 4) check_all($sformatf("done%0d", i), 9'b0, 1'b0, 1'b1, 3'd1, 3'd7);
    end
    rst = 1'b1;
    tick();
    check_all("reset_done", LED_C, 1'b0, 1'b0, 3'd0, 3'd0);
    rst = 1'b0;
    bus.press_l = 1'b0;
    bus.press_r = 1'b0;
    tick();
    check_all("post_reset", LED_C, 1'b0, 1'b0, 3'd0, 3'd0);

    // reset on the same edge as a winning left press
    for (int p = 0; p < 4; p++) pulse_l();
    check_all("at_left_edge", 9'b100000000, 1'b0, 1'b0, 3'd0, 3'd0);
    bus.press_l = 1'b0;
    tick();
    rst = 1'b1;
    bus.press_l = 1'b1;
    tick();
    check_all("reset_prio", LED_C, 1'b0, 1'b0, 3'd0, 3'd0);
    rst = 1'b0;
    tick();
    check_all("reset_prio_hold", LED_C, 1'b0, 1'b0, 3'd0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tug_playfield.md
# tug_playfield

Consumes the two per-player press signals of the tug-of-war game and turns them into game state. The computer player's `press_l` comes from the registered switch-vs-LFSR comparator; `press_r` is the human key, already synchronized. The block edge-detects both inputs, moves a one-hot light along the playfield, detects round wins, holds the win display, keeps per-player scores, and ends the game at a maximum score.

## Interface

- `NUM_LIGHTS`, 9: playfield width; odd, ≥3; centre index `C = (NUM_LIGHTS-1)/2`.
- `HOLD_CYCLES`, 8: cycles the win display is held before the next round; ≥1.
- `SCORE_W`, 3: score counter width; game ends at `2^SCORE_W-1`.

- `Clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input in the same cycle.
- `press_l` in 1: computer press level, from the comparator.
- `press_r` in 1: human press level, synchronized.
- `led` out `NUM_LIGHTS`: playfield; one-hot during play, all zeros in win/done states; bit `NUM_LIGHTS-1` is leftmost.
- `win_l` out 1: high while the left player's win is displayed or the game is over with left as winner.
- `win_r` out 1: same for the right player.
- `score_l` out `SCORE_W`: left rounds won.
- `score_r` out `SCORE_W`: right rounds won.

## Operation

- Edge detect:
  - Registers `prev_l`/`prev_r` capture the inputs every non-reset cycle, in all states.
  - `pulse_x = press_x & ~prev_x`.
  - One pulse per low→high transition, however long the input is held.
- Position register `pos`, range 0..NUM_LIGHTS-1; `led = 1 << pos` in PLAY.
- States: PLAY, WIN_L, WIN_R, DONE.
- PLAY:
  - `pulse_l` only: if `pos < NUM_LIGHTS-1`, increment `pos`; else go to WIN_L, `score_l += 1`, hold counter = 0.
  - `pulse_r` only: if `pos > 0`, decrement `pos`; else go to WIN_R, `score_r += 1`, hold counter = 0.
  - Both pulses in the same cycle, or neither: no change.
- WIN_L / WIN_R:
  - `led` = 0; the matching `win_x` = 1.
  - All pulses are ignored.
  - Hold counter increments each cycle. On the cycle it equals `HOLD_CYCLES-1`, the next state is PLAY with `pos = C`.
  - Exception: if the new score equals `2^SCORE_W-1`, go to DONE at entry instead of running the hold.
- DONE:
  - `led` = 0; the winner's `win_x` stays 1.
  - Scores are frozen and all pulses are ignored until `reset`.
- Scores never wrap, because DONE is entered at the maximum.

## Timing

- Reset values:
  - state PLAY, `pos = C`, so `led` shows only bit C.
  - `win_l = win_r = 0`, `score_l = score_r = 0`, hold counter 0.
  - `prev_l = prev_r = 1`, so an input held high through reset never produces a pulse.
- Move latency: when the first edge samples `press_x = 1` with `prev_x = 0`, `led` updates on that same edge (1 cycle from input change, registered output).
- Win entry: the winning edge sets `led = 0`, `win_x = 1` and the incremented score together.
- Win display lasts exactly `HOLD_CYCLES` cycles. On the next edge: `led` shows only bit C, `win_x = 0`, score retained.
- A pulse arriving on the first PLAY cycle after the hold is acted on normally.
- All outputs are registered; there are no combinational input→output paths.

## Test plan

- **Reset with `press_r` held high:** assert `reset` with `press_r` = 1, release, keep `press_r` high 5 cycles → `led` = 9'b000010000. Drop then raise `press_r` → `led` = 9'b000001000.
- **Left win:**
  - From reset, 4 `press_l` pulses → `led` = 9'b100000000.
  - 5th pulse → `led` = 0, `win_l` = 1, `score_l` = 1 for exactly 8 cycles.
  - Then `led` = 9'b000010000, `win_l` = 0.
- **Simultaneous presses:** `press_l` and `press_r` rise on the same edge at centre → `led` unchanged at 9'b000010000. Next, `press_l` alone falls and rises → 9'b000100000.
- **Pulses during hold:** after a right win, toggle both inputs every cycle during the 8-cycle hold → no score change; `led` = 9'b000010000 afterwards.
- **Game over:**
  - Right wins 7 rounds → after the 7th win, `score_r` = 7, `win_r` stays 1, `led` = 0.
  - 20 further pulses on each input → no change.
  - `reset` → all reset values.
- **Reset priority:** `reset` asserted on the same edge as a winning `press_l` pulse at `pos` = 8 → `score_l` = 0, `win_l` = 0, `led` = 9'b000010000.
